apb_tx_sequencer: RTL and testbench
===================================

# apb_tx_sequencer

APB master that programs the serial transmitter's APB slave (TX side of `top`) for one complete transmission: configuration word, a burst of payload words pushed into the TX data FIFO, prescaler, frame count, then a start/release pulse on the control register. It replaces hand-driven bus stimulus and host firmware for autonomous transfers, and sits on the PCLK_tx domain between a payload source (valid/ready stream) and the TX slave's APB port.

## Interface

- ADDRESSWIDTH, 3, APB address width
- DATAWIDTH, 18, APB data and payload width
- CNTW, 8, payload word-count width (max 2^CNTW-1 words per job)
- START_BIT, 3, control-register bit pulsed to launch transmission
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort
- PCLK  in  1  clock
- PRESETn  in  1  reset: one clock; reset is asynchronous and active-low
- start_i  in  1  job request, sampled in IDLE only
- cfg_i  in  DATAWIDTH  value written to addr 0
- presc_i  in  DATAWIDTH  value written to addr 3
- count_i  in  DATAWIDTH  value written to addr 4
- ctrl_i  in  DATAWIDTH  base value for addr 1
- nwords_i  in  CNTW  payload words to push to addr 2
- data_i  in  DATAWIDTH  payload word
- data_valid_i  in  1  payload valid
- data_ready_o  out  1  payload accepted when valid&ready
- PADDR_o / PWDATA_o  out  ADDRESSWIDTH / DATAWIDTH  APB address / write data
- PWRITE_o, PSELx_o, PENABLE_o  out  1 each  APB controls
- PREADY_i  in  1  slave ready
- PRDATA_i  in  DATAWIDTH  unused, reserved for readback
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse, job completed
- err_o  out  1  one-cycle pulse, job aborted on timeout

## Operation

- Bus FSM: IDLE, SETUP (PSELx=1, PENABLE=0), ACCESS (PSELx=1, PENABLE=1), GAP (PSELx=0). Every write is SETUP -> ACCESS (held until PREADY_i=1) -> GAP. PWRITE_o=1 only in SETUP/ACCESS. PADDR_o/PWDATA_o stable from SETUP through ACCESS.
- Step sequence per job: CFG (addr 0, cfg) -> DATA x nwords (addr 2, payload) -> PRESC (addr 3) -> CNT (addr 4) -> GO (addr 1, ctrl | 1<<START_BIT) -> REL (addr 1, ctrl & ~(1<<START_BIT)).
- start_i in IDLE latches cfg_i, presc_i, count_i, ctrl_i, nwords_i; inputs may change afterwards. start_i while busy ignored.
- nwords=0: DATA step skipped, CFG goes directly to PRESC.
- Payload: data_ready_o=1 only in a GAP cycle whose next step is DATA (and in IDLE->first-DATA is never direct since CFG precedes). Handshake loads PWDATA and moves to SETUP next cycle; no valid -> stay in GAP, PSELx=0. Word counter decrements per accepted word.
- Timeout: counter resets on SETUP, increments each ACCESS cycle with PREADY_i=0; reaching TIMEOUT -> drop PSELx/PENABLE, err_o pulse, IDLE. No further writes of that job.
- Completion: REL ACCESS with PREADY_i=1 -> next cycle IDLE, done_o=1 for that cycle.

## Timing

- Reset (async, PRESETn=0): state IDLE; all outputs 0 (PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, err_o); counters 0. Reset mid-transfer drops PSELx immediately.
- start_i high at edge k -> SETUP of CFG after edge k; busy_o=1 from SETUP of CFG through ACCESS of REL.
- Zero-wait slave, payload always valid: 3 cycles per write; job of N words = 3*(N+5) cycles from first SETUP to done_o cycle inclusive.
- Each PREADY_i=0 cycle in ACCESS adds one cycle.
- done_o and err_o never assert together; neither asserts with busy_o=1.
- start_i high in the done_o cycle is accepted (state is IDLE).

## Test plan

- cfg 0x060, nwords 3, payload 1,2,3, presc 0x08, count 0x0001, ctrl 0x50, PREADY=1 -> writes (0,0x060),(2,1),(2,2),(2,3),(3,0x08),(4,0x0001),(1,0x58),(1,0x50); done_o exactly 24 cycles after first SETUP.
- Same job, data_valid_i low 5 cycles before word 2 -> PSELx stays 0, data_ready_o=1 for those 5 cycles; total 29 cycles, data order unchanged.
- nwords 0 -> no addr-2 write; 5 writes, done_o at cycle 15.
- PREADY low 2 cycles on PRESC write (TIMEOUT 16) -> PENABLE held 3 cycles, PADDR/PWDATA stable; done_o at cycle 26 for 3-word job.
- PREADY stuck low on CNT write, TIMEOUT 4 -> err_o after 4 ACCESS cycles, no addr-1 write, busy_o=0; new start_i runs full job.
- PRESETn low during DATA ACCESS -> all outputs 0 same instant; after release, start_i restarts from CFG; start_i pulses while busy produce no extra writes.

Source files
------------

// File: rtl/apb_tx_sequencer.sv
// APB master that programs the TX slave for one transmission: cfg, payload burst, presc, count, start/release.
// Latency: SETUP follows start_i by one cycle; each write is SETUP/ACCESS/GAP, 3*(nwords+5) cycles at zero wait.
// Backpressure: PREADY_i low stretches ACCESS (aborts after TIMEOUT cycles); payload waits in GAP with PSELx low.
module apb_tx_sequencer #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 18,
  parameter int CNTW         = 8,
  parameter int START_BIT    = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    start_i,
  input  logic [DATAWIDTH-1:0]    cfg_i,
  input  logic [DATAWIDTH-1:0]    presc_i,
  input  logic [DATAWIDTH-1:0]    count_i,
  input  logic [DATAWIDTH-1:0]    ctrl_i,
  input  logic [CNTW-1:0]         nwords_i,
  input  logic [DATAWIDTH-1:0]    data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [ADDRESSWIDTH-1:0] PADDR_o,
  output logic [DATAWIDTH-1:0]    PWDATA_o,
  output logic                    PWRITE_o,
  output logic                    PSELx_o,
  output logic                    PENABLE_o,
  input  logic                    PREADY_i,
  input  logic [DATAWIDTH-1:0]    PRDATA_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATAWIDTH-1:0] START_MASK = DATAWIDTH'(1) << START_BIT;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;
  typedef enum logic [2:0] {SP_CFG, SP_DATA, SP_PRESC, SP_CNT, SP_GO, SP_REL} step_t;

  state_t                  state_q, state_d;
  step_t                   step_q, step_d;
  logic [CNTW-1:0]         words_q, words_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
  logic [DATAWIDTH-1:0]    presc_q, count_q, ctrl_q;
  logic                    done_q, done_d, err_q, err_d, latch_en;

  // Readback data is reserved for a future verify step.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA_i;

  // State, step, counters, bus registers and latched job parameters.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      step_q   <= SP_CFG;
      words_q  <= '0;
      tmo_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      words_q  <= words_d;
      tmo_q    <= tmo_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (latch_en) begin
        presc_q <= presc_i;
        count_q <= count_i;
        ctrl_q  <= ctrl_i;
      end
    end
  end

  // Next-state: bus phase sequencing, step advance, payload handshake and timeout abort.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    words_d  = words_q;
    tmo_d    = tmo_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          latch_en = 1'b1;
          state_d  = ST_SETUP;
          step_d   = SP_CFG;
          words_d  = nwords_i;
          tmo_d    = '0;
          paddr_d  = ADDRESSWIDTH'(0);
          pwdata_d = cfg_i;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        tmo_d   = '0;
      end
      ST_ACCESS: begin
        if (PREADY_i) begin
          if (step_q == SP_REL) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            unique case (step_q)
              SP_CFG, SP_DATA: step_d = (words_q != '0) ? SP_DATA : SP_PRESC;
              SP_PRESC:        step_d = SP_CNT;
              SP_CNT:          step_d = SP_GO;
              default:         step_d = SP_REL;
            endcase
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        // GAP: a DATA step waits here for the payload; other steps issue immediately.
        if (step_q == SP_DATA) begin
          if (data_valid_i) begin
            state_d  = ST_SETUP;
            paddr_d  = ADDRESSWIDTH'(2);
            pwdata_d = data_i;
            words_d  = words_q - 1'b1;
          end
        end else begin
          state_d = ST_SETUP;
          unique case (step_q)
            SP_PRESC: begin paddr_d = ADDRESSWIDTH'(3); pwdata_d = presc_q;               end
            SP_CNT:   begin paddr_d = ADDRESSWIDTH'(4); pwdata_d = count_q;               end
            SP_GO:    begin paddr_d = ADDRESSWIDTH'(1); pwdata_d = ctrl_q | START_MASK;   end
            default:  begin paddr_d = ADDRESSWIDTH'(1); pwdata_d = ctrl_q & ~START_MASK;  end
          endcase
        end
      end
    endcase
  end

  assign PSELx_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE_o    = (state_q == ST_ACCESS);
  assign PWRITE_o     = PSELx_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign data_ready_o = (state_q == ST_GAP) && (step_q == SP_DATA);
  assign PADDR_o      = paddr_q;
  assign PWDATA_o     = pwdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_apb_tx_sequencer.sv
// Self-checking bench for apb_tx_sequencer: directed plan jobs plus randomized back-to-back jobs.
// Latency: jobs are checked for exact done/err cycle counted from the first SETUP.
// Backpressure: bench randomizes PREADY wait states and payload valid stalls.
module tb_apb_tx_sequencer;
  localparam int AW = 3, DW = 18, CW = 8, SB = 3, TO = 4;
  localparam int LIMIT = 3000;

  logic          PCLK = 1'b0, PRESETn = 1'b0, start_i = 1'b0;
  logic [DW-1:0] cfg_i = '0, presc_i = '0, count_i = '0, ctrl_i = '0, data_i = '0, PRDATA_i = '0;
  logic [CW-1:0] nwords_i = '0;
  logic          data_valid_i = 1'b0, PREADY_i = 1'b0;
  logic          data_ready_o, PWRITE_o, PSELx_o, PENABLE_o, busy_o, done_o, err_o;
  logic [AW-1:0] PADDR_o;
  logic [DW-1:0] PWDATA_o;

  apb_tx_sequencer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .CNTW(CW), .START_BIT(SB), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start_i), .cfg_i(cfg_i), .presc_i(presc_i),
    .count_i(count_i), .ctrl_i(ctrl_i), .nwords_i(nwords_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .PADDR_o(PADDR_o),
    .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o), .PSELx_o(PSELx_o), .PENABLE_o(PENABLE_o),
    .PREADY_i(PREADY_i), .PRDATA_i(PRDATA_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 PCLK = ~PCLK;

  int checks = 0, errors = 0;

  // Job description
  logic [DW-1:0] j_cfg, j_presc, j_count, j_ctrl;
  logic [DW-1:0] j_pay[$];
  int            j_stall[$];   // valid-low cycles before payload word k
  int            j_wait[$];    // PREADY-low cycles on write i
  int            j_stuck;      // write index whose PREADY never rises (-1 none)
  int            j_rst_at;     // write index at whose ACCESS reset is asserted (-1 none)

  // Observed results
  logic [AW+DW-1:0] got[$];
  int               r_done, r_err, r_first, r_viol, r_rdy;
  bit               r_to;
  logic [27:0]      r_rst;

  // Reference model results
  logic [AW+DW-1:0] exp_w[$];
  int               exp_cycles;
  bit               exp_err;

  function automatic int wait_of(int i);
    return (i >= 0 && i < j_wait.size()) ? j_wait[i] : 0;
  endfunction

  function automatic int stall_of(int k);
    return (k >= 0 && k < j_stall.size()) ? j_stall[k] : 0;
  endfunction

  // Expected write list and job duration, from the step order and per-write cost.
  function automatic void build_model();
    logic [DW-1:0] m;
    int n, total;
    m = DW'(1) << SB;
    n = j_pay.size();
    exp_w.delete();
    exp_w.push_back({3'd0, j_cfg});
    foreach (j_pay[i]) exp_w.push_back({3'd2, j_pay[i]});
    exp_w.push_back({3'd3, j_presc});
    exp_w.push_back({3'd4, j_count});
    exp_w.push_back({3'd1, j_ctrl | m});
    exp_w.push_back({3'd1, j_ctrl & ~m});
    total = exp_w.size();
    exp_cycles = 0;
    exp_err = 0;
    for (int i = 0; i < total; i++) begin
      if (i >= 1 && i <= n) exp_cycles += stall_of(i - 1);
      if (i == j_stuck) begin
        exp_cycles += 1 + TO + 1;
        exp_err = 1;
        break;
      end
      exp_cycles += 3 + wait_of(i);
    end
    if (exp_err) while (exp_w.size() > j_stuck) void'(exp_w.pop_back());
  endfunction

  function automatic void plan_job(int nw);
    j_cfg = 18'h060; j_presc = 18'h08; j_count = 18'h0001; j_ctrl = 18'h50;
    j_pay.delete();
    for (int i = 1; i <= nw; i++) j_pay.push_back(DW'(i));
    j_stall.delete(); j_wait.delete(); j_stuck = -1; j_rst_at = -1;
  endfunction

  // Runs one job starting at the current negedge; sampling and driving happen at negedges.
  task automatic run_job();
    int cyc, w, k, wait_rem, stall_rem;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    bit fin;
    got.delete();
    r_done = -1; r_err = -1; r_first = -1; r_viol = 0; r_rdy = 0; r_to = 0; r_rst = '1;
    s_a = '0; s_d = '0;
    cfg_i = j_cfg; presc_i = j_presc; count_i = j_count; ctrl_i = j_ctrl;
    nwords_i = CW'(j_pay.size());
    start_i = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    cyc = 1; w = -1; k = 0; wait_rem = 0; stall_rem = stall_of(0); fin = 0;
    while (!fin) begin
      if (done_o && err_o) r_viol++;
      if ((done_o || err_o) && busy_o) r_viol++;
      if (PWRITE_o !== PSELx_o) r_viol++;
      if (PENABLE_o && !PSELx_o) r_viol++;
      if (PSELx_o && !busy_o) r_viol++;
      if (data_ready_o && PSELx_o) r_viol++;
      if (done_o) begin
        r_done = cyc; fin = 1;
      end else if (err_o) begin
        r_err = cyc; fin = 1;
      end else if (cyc > LIMIT) begin
        r_to = 1; fin = 1;
      end else begin
        if (PSELx_o && !PENABLE_o) begin
          w++;
          if (r_first < 0) r_first = cyc;
          s_a = PADDR_o; s_d = PWDATA_o;
          wait_rem = wait_of(w);
        end
        if (PENABLE_o && (PADDR_o !== s_a || PWDATA_o !== s_d)) r_viol++;
        if (PENABLE_o && w == j_rst_at) begin
          PRESETn = 1'b0;
          #1;
          r_rst = {PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, err_o};
          fin = 1;
        end else begin
          if (PENABLE_o) begin
            if (w == j_stuck) PREADY_i = 1'b0;
            else if (wait_rem > 0) begin PREADY_i = 1'b0; wait_rem--; end
            else begin PREADY_i = 1'b1; got.push_back({PADDR_o, PWDATA_o}); end
          end else PREADY_i = 1'($urandom);
          if (data_ready_o) begin
            r_rdy++;
            if (stall_rem > 0) begin
              data_valid_i = 1'b0; stall_rem--;
            end else begin
              data_valid_i = 1'b1;
              data_i = (k < j_pay.size()) ? j_pay[k] : '0;
              k++;
              stall_rem = stall_of(k);
            end
          end else begin
            data_valid_i = 1'($urandom);
            data_i = DW'($urandom);
          end
          start_i = busy_o ? 1'($urandom) : 1'b0;
          cfg_i = DW'($urandom); presc_i = DW'($urandom); count_i = DW'($urandom);
          ctrl_i = DW'($urandom); nwords_i = CW'($urandom);
          @(negedge PCLK);
          cyc++;
        end
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, err_o} !== 28'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, data_ready_o, busy_o, done_o, err_o});
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({busy_o, PSELx_o, done_o, err_o} !== 4'h0) begin
      errors++; $display("FAIL reset_idle got %b exp 0000", {busy_o, PSELx_o, done_o, err_o});
    end
  endtask

  task automatic test_basic();
    plan_job(3); build_model(); run_job();
    checks++; if (r_first !== 1) begin errors++; $display("FAIL basic_first_setup got %0d exp 1", r_first); end
    checks++; if (r_done !== 24) begin errors++; $display("FAIL basic_done_cycle got %0d exp 24", r_done); end
    checks++; if (r_viol !== 0) begin errors++; $display("FAIL basic_protocol got %0d violations exp 0", r_viol); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL basic_nwrites got %0d exp 8", got.size()); end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL basic_write%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
    checks++; if (got.size() > 6 && got[6] !== {3'd1, 18'h00058}) begin errors++; $display("FAIL basic_go got %h exp %h", got[6], {3'd1, 18'h00058}); end
    @(negedge PCLK);
    checks++; if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse got %b exp 00", {done_o, busy_o}); end
  endtask

  task automatic test_valid_stall();
    plan_job(3); j_stall = '{0, 5}; build_model(); run_job();
    checks++; if (r_done !== 29) begin errors++; $display("FAIL stall_done_cycle got %0d exp 29", r_done); end
    checks++; if (r_rdy !== 8) begin errors++; $display("FAIL stall_ready_cycles got %0d exp 8", r_rdy); end
    checks++; if (r_viol !== 0) begin errors++; $display("FAIL stall_protocol got %0d violations exp 0", r_viol); end
    checks++; if (got.size() !== exp_w.size()) begin errors++; $display("FAIL stall_nwrites got %0d exp %0d", got.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL stall_write%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    plan_job(2); j_cfg = 18'h3ABCD; j_ctrl = 18'h3FFFF; build_model(); run_job();
    checks++; if (r_first !== 1) begin errors++; $display("FAIL b2b_first_setup got %0d exp 1", r_first); end
    checks++; if (r_done !== 21) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 21", r_done); end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_write%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_zero_words();
    plan_job(0); build_model(); run_job();
    checks++; if (r_done !== 15) begin errors++; $display("FAIL zero_done_cycle got %0d exp 15", r_done); end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL zero_nwrites got %0d exp 5", got.size()); end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL zero_write%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_wait_states();
    plan_job(3); j_wait = '{0, 0, 0, 0, 2}; build_model(); run_job();
    checks++; if (r_done !== 26) begin errors++; $display("FAIL wait_done_cycle got %0d exp 26", r_done); end
    checks++; if (r_viol !== 0) begin errors++; $display("FAIL wait_protocol got %0d violations exp 0", r_viol); end
    checks++; if (got.size() > 4 && got[4] !== {3'd3, 18'h8}) begin errors++; $display("FAIL wait_presc got %h exp %h", got[4], {3'd3, 18'h8}); end
    plan_job(3); j_wait = '{0, 0, 0, 0, 0, 0, TO - 1}; build_model(); run_job();
    checks++; if (r_done !== 24 + TO - 1) begin errors++; $display("FAIL wait_max_done got %0d exp %0d", r_done, 24 + TO - 1); end
    checks++; if (r_err !== -1) begin errors++; $display("FAIL wait_max_no_err got %0d exp -1", r_err); end
  endtask

  task automatic test_timeout();
    plan_job(3); j_stuck = 5; build_model(); run_job();
    checks++; if (r_err !== 21) begin errors++; $display("FAIL tmo_err_cycle got %0d exp 21", r_err); end
    checks++; if (r_done !== -1) begin errors++; $display("FAIL tmo_no_done got %0d exp -1", r_done); end
    checks++; if ({busy_o, PSELx_o, PENABLE_o} !== 3'b000) begin errors++; $display("FAIL tmo_idle got %b exp 000", {busy_o, PSELx_o, PENABLE_o}); end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL tmo_nwrites got %0d exp 5", got.size()); end
    plan_job(3); build_model(); run_job();
    checks++; if (r_done !== 24) begin errors++; $display("FAIL tmo_restart_done got %0d exp 24", r_done); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL tmo_restart_nwrites got %0d exp 8", got.size()); end
  endtask

  task automatic test_reset_mid();
    plan_job(3); j_rst_at = 2; build_model(); run_job();
    checks++; if (r_rst !== 28'h0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", r_rst); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    plan_job(3); build_model(); run_job();
    checks++; if (r_first !== 1) begin errors++; $display("FAIL rstmid_first_setup got %0d exp 1", r_first); end
    checks++; if (r_done !== 24) begin errors++; $display("FAIL rstmid_done got %0d exp 24", r_done); end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rstmid_write%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_random();
    int nw;
    for (int t = 0; t < 30; t++) begin
      j_cfg = DW'($urandom); j_presc = DW'($urandom); j_count = DW'($urandom); j_ctrl = DW'($urandom);
      nw = $urandom_range(0, 10);
      j_pay.delete(); j_stall.delete(); j_wait.delete();
      for (int i = 0; i < nw; i++) begin
        j_pay.push_back(DW'($urandom));
        j_stall.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end
      for (int i = 0; i < nw + 5; i++) j_wait.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, TO - 1) : 0);
      j_stuck = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nw + 4) : -1;
      j_rst_at = -1;
      build_model();
      run_job();
      checks++; if (r_to !== 0) begin errors++; $display("FAIL rand%0d_budget expired after %0d cycles", t, LIMIT); end
      checks++; if (r_first !== 1) begin errors++; $display("FAIL rand%0d_first_setup got %0d exp 1", t, r_first); end
      checks++;
      if (exp_err ? (r_err !== exp_cycles || r_done !== -1) : (r_done !== exp_cycles || r_err !== -1)) begin
        errors++; $display("FAIL rand%0d_end got done %0d err %0d exp %s at %0d", t, r_done, r_err, exp_err ? "err" : "done", exp_cycles);
      end
      checks++; if (r_viol !== 0) begin errors++; $display("FAIL rand%0d_protocol got %0d violations exp 0", t, r_viol); end
      checks++; if (got.size() !== exp_w.size()) begin errors++; $display("FAIL rand%0d_nwrites got %0d exp %0d", t, got.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rand%0d_write%0d got %h exp %h", t, i, got[i], exp_w[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_stall();
    test_back_to_back();
    test_zero_words();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
